// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream bundle used on both sides of axis_pkt_fifo.
//   tvalid/tready : beat handshake
//   tdata         : DATA_W payload
//   tkeep         : DATA_W/8 byte qualifiers
//   tlast         : end of packet
// The master modport drives the payload; the slave modport drives tready.
interface axis_pkt_fifo_if #(
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Parametrised AXI4-Stream FIFO with first-word-fall-through output and an
// optional store-and-forward packet mode (PKT_MODE=1).
// Ports:
//   iSYS_CLK      : clock, rising edge
//   iSYS_RST      : asynchronous active-low reset
//   s_axis        : write-side stream (slave modport)
//   m_axis        : read-side stream (master modport)
//   oWR_COUNT     : total occupancy 0..DEPTH
//   oRD_COUNT     : readable words (complete-packet words in packet mode)
//   oPKT_COUNT    : number of TLAST beats held
//   oALMOST_FULL  : occupancy >= AFULL_TH
//   oALMOST_EMPTY : occupancy <= AEMPTY_TH
module axis_pkt_fifo #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PKT_MODE  = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    axis_pkt_fifo_if.slave  s_axis,
    axis_pkt_fifo_if.master m_axis,
    output logic [AW:0]     oWR_COUNT,
    output logic [AW:0]     oRD_COUNT,
    output logic [AW:0]     oPKT_COUNT,
    output logic            oALMOST_FULL,
    output logic            oALMOST_EMPTY
);
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;
    localparam int unsigned PW     = AW + 1;

    logic [ENT_W-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_last_ptr;
    logic [PW-1:0] r_pkt_cnt;
    logic [PW-1:0] r_wr_cnt;
    logic [PW-1:0] r_rd_cnt;
    logic          r_force;
    logic          r_s_tready;
    logic          r_m_tvalid;
    logic          r_afull;
    logic          r_aempty;

    logic [ENT_W-1:0] w_rd_entry;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW-1:0]    w_last_ptr_nxt;
    logic [PW-1:0]    w_occ_nxt;
    logic [PW-1:0]    w_pkt_nxt;
    logic [PW-1:0]    w_rd_cnt_nxt;
    logic             w_force_nxt;
    logic             w_tvalid_nxt;

    // First-word-fall-through read port
    assign w_rd_entry    = r_mem[r_rd_ptr[AW-1:0]];
    assign m_axis.tdata  = w_rd_entry[ENT_W-1 -: DATA_W];
    assign m_axis.tkeep  = w_rd_entry[KEEP_W:1];
    assign m_axis.tlast  = w_rd_entry[0];
    assign m_axis.tvalid = r_m_tvalid;
    assign s_axis.tready = r_s_tready;

    assign oWR_COUNT     = r_wr_cnt;
    assign oRD_COUNT     = r_rd_cnt;
    assign oPKT_COUNT    = r_pkt_cnt;
    assign oALMOST_FULL  = r_afull;
    assign oALMOST_EMPTY = r_aempty;

    // Next-state of pointers, counts and flags; all flags are registered from
    // these so they change on the same edge as the pointers.
    always_comb begin
        w_wr           = s_axis.tvalid & r_s_tready;
        w_rd           = r_m_tvalid & m_axis.tready;
        w_wr_last      = w_wr & s_axis.tlast;
        w_rd_last      = w_rd & w_rd_entry[0];
        w_wr_ptr_nxt   = r_wr_ptr + PW'(w_wr);
        w_rd_ptr_nxt   = r_rd_ptr + PW'(w_rd);
        w_last_ptr_nxt = w_wr_last ? w_wr_ptr_nxt : r_last_ptr;
        w_occ_nxt      = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_pkt_nxt      = r_pkt_cnt + PW'(w_wr_last) - PW'(w_rd_last);
        w_force_nxt    = 1'b0;
        w_tvalid_nxt   = (w_occ_nxt != '0);
        w_rd_cnt_nxt   = w_occ_nxt;

        if (PKT_MODE != 0) begin
            // A full FIFO with no complete packet can only be an oversize
            // packet; release it as cut-through until its TLAST leaves.
            w_force_nxt  = (r_force & ~w_rd_last)
                         | ((w_occ_nxt == PW'(DEPTH)) & (w_pkt_nxt == '0));
            // Forced release must still stop when the FIFO runs dry.
            w_tvalid_nxt = (w_pkt_nxt != '0) | (w_force_nxt & (w_occ_nxt != '0));
            if (w_force_nxt) begin
                w_rd_cnt_nxt = w_occ_nxt;
            end else if (w_pkt_nxt != '0) begin
                // Words up to and including the newest stored TLAST
                w_rd_cnt_nxt = w_last_ptr_nxt - w_rd_ptr_nxt;
            end else begin
                w_rd_cnt_nxt = '0;
            end
        end
    end

    // Pointer, count and flag registers
    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last_ptr <= '0;
            r_pkt_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_force    <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_last_ptr <= w_last_ptr_nxt;
            r_pkt_cnt  <= w_pkt_nxt;
            r_wr_cnt   <= w_occ_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_force    <= w_force_nxt;
            r_s_tready <= (w_occ_nxt != PW'(DEPTH));
            r_m_tvalid <= w_tvalid_nxt;
            r_afull    <= (w_occ_nxt >= PW'(AFULL_TH));
            r_aempty   <= (w_occ_nxt <= PW'(AEMPTY_TH));
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge iSYS_CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
        end
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one packet-mode instance share
// the stimulus; `sel` steers traffic to one of them at a time.
module tb_axis_pkt_fifo;
    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          sel;
    logic          s_vld;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_last;
    logic          m_rdy;
    bit            chk_en;

    axis_pkt_fifo_if #(.DATA_W(DW)) ct_s ();
    axis_pkt_fifo_if #(.DATA_W(DW)) ct_m ();
    axis_pkt_fifo_if #(.DATA_W(DW)) pk_s ();
    axis_pkt_fifo_if #(.DATA_W(DW)) pk_m ();

    logic [AW:0] ct_wrc, ct_rdc, ct_pkc, pk_wrc, pk_rdc, pk_pkc;
    logic        ct_af, ct_ae, pk_af, pk_ae;

    assign ct_s.tvalid = s_vld & ~sel;
    assign ct_s.tdata  = s_data;
    assign ct_s.tkeep  = s_keep;
    assign ct_s.tlast  = s_last;
    assign ct_m.tready = m_rdy & ~sel;
    assign pk_s.tvalid = s_vld & sel;
    assign pk_s.tdata  = s_data;
    assign pk_s.tkeep  = s_keep;
    assign pk_s.tlast  = s_last;
    assign pk_m.tready = m_rdy & sel;

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
        .iSYS_CLK(clk), .iSYS_RST(rst_n), .s_axis(ct_s), .m_axis(ct_m),
        .oWR_COUNT(ct_wrc), .oRD_COUNT(ct_rdc), .oPKT_COUNT(ct_pkc),
        .oALMOST_FULL(ct_af), .oALMOST_EMPTY(ct_ae));

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(1)) u_pk (
        .iSYS_CLK(clk), .iSYS_RST(rst_n), .s_axis(pk_s), .m_axis(pk_m),
        .oWR_COUNT(pk_wrc), .oRD_COUNT(pk_rdc), .oPKT_COUNT(pk_pkc),
        .oALMOST_FULL(pk_af), .oALMOST_EMPTY(pk_ae));

    // Observed outputs of the selected instance
    logic          o_srdy, o_mvld, o_last, o_af, o_ae;
    logic [DW-1:0] o_data;
    logic [KW-1:0] o_keep;
    logic [AW:0]   o_wrc, o_rdc, o_pkc;
    assign o_srdy = sel ? pk_s.tready : ct_s.tready;
    assign o_mvld = sel ? pk_m.tvalid : ct_m.tvalid;
    assign o_data = sel ? pk_m.tdata  : ct_m.tdata;
    assign o_keep = sel ? pk_m.tkeep  : ct_m.tkeep;
    assign o_last = sel ? pk_m.tlast  : ct_m.tlast;
    assign o_wrc  = sel ? pk_wrc : ct_wrc;
    assign o_rdc  = sel ? pk_rdc : ct_rdc;
    assign o_pkc  = sel ? pk_pkc : ct_pkc;
    assign o_af   = sel ? pk_af  : ct_af;
    assign o_ae   = sel ? pk_ae  : ct_ae;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model: a queue of beats ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t mq[$];
    beat_t md_beat;
    bit    m_force, e_srdy, e_mvld, md_wr, md_rd;

    function automatic int n_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i].l) n++;
        return n;
    endfunction

    function automatic int done_words();
        int w = 0;
        foreach (mq[i]) if (mq[i].l) w = i + 1;
        return w;
    endfunction

    function automatic int exp_rdc();
        if (!sel || m_force) return mq.size();
        return done_words();
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_force = 1'b0;
            e_srdy  = 1'b0;
            e_mvld  = 1'b0;
        end else begin
            md_wr = s_vld && e_srdy;
            md_rd = e_mvld && m_rdy;
            if (md_rd) begin
                md_beat = mq.pop_front();
                if (md_beat.l) m_force = 1'b0;
            end
            if (md_wr) begin
                md_beat.d = s_data;
                md_beat.k = s_keep;
                md_beat.l = s_last;
                mq.push_back(md_beat);
            end
            if (sel && mq.size() == DEPTH && n_pkts() == 0) m_force = 1'b1;
            e_srdy = mq.size() < DEPTH;
            e_mvld = sel ? (n_pkts() != 0 || (m_force && mq.size() != 0)) : (mq.size() != 0);
        end
    end

    // Per-cycle scoreboard comparison against the model
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            chk("sb s_tready", 64'(o_srdy), 64'(e_srdy));
            chk("sb m_tvalid", 64'(o_mvld), 64'(e_mvld));
            chk("sb wr_count", 64'(o_wrc), 64'(mq.size()));
            chk("sb rd_count", 64'(o_rdc), 64'(exp_rdc()));
            chk("sb pkt_count", 64'(sel ? n_pkts() : 0) | 64'(o_pkc & {(AW+1){~sel}}), 64'(o_pkc));
            chk("sb almost_full", 64'(o_af), 64'(mq.size() >= DEPTH - 2));
            chk("sb almost_empty", 64'(o_ae), 64'(mq.size() <= 2));
            if (e_mvld && mq.size() != 0) begin
                chk("sb tdata", o_data, mq[0].d);
                chk("sb tkeep", 64'(o_keep), 64'(mq[0].k));
                chk("sb tlast", 64'(o_last), 64'(mq[0].l));
            end
        end
    end

    // Move n beats (base+i) through the selected FIFO, optionally with random
    // stalls on both sides, and check the delivered order.
    task automatic xfer(input string tag, input int n, input int sent0,
                        input logic [63:0] base, input int last_mod, input bit rnd);
        logic [63:0] got[$];
        int sent;
        bit acc;
        sent = sent0;
        for (int c = 0; c < 4000 && got.size() < n; c++) begin
            s_vld  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            s_data = base + 64'(sent);
            s_keep = rnd ? 8'($urandom) : 8'hFF;
            s_last = (sent % last_mod) == last_mod - 1;
            m_rdy  = !rnd || $urandom_range(0, 2) != 0;
            acc    = s_vld && o_srdy;
            if (o_mvld && m_rdy) got.push_back(o_data);
            step();
            if (acc) sent++;
        end
        s_vld  = 1'b0;
        s_last = 1'b0;
        chk({tag, " beat count"}, 64'(got.size()), 64'(n));
        foreach (got[i]) chk({tag, " order"}, got[i], base + 64'(i));
    endtask

    typedef struct {
        logic          vld;
        logic [DW-1:0] d;
        logic          last;
        logic          rdy;
        logic          e_srdy;
        logic          e_mvld;
        logic [AW:0]   e_cnt;
        logic          e_chk;
        logic [DW-1:0] e_d;
        logic          e_last;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        tbl[0] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{1'b1, 64'hDEADBEEFCAFEBABE, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 64'hDEADBEEFCAFEBABE, 1'b0};
        tbl[2] = '{1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 64'h0123456789ABCDEF, 1'b1};
        tbl[3] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0, 1'b0};

        sel = 1'b0; s_vld = 1'b0; s_data = '0; s_keep = '1; s_last = 1'b0;
        m_rdy = 1'b0; chk_en = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset s_tready", 64'(o_srdy), 64'd0);
        chk("reset m_tvalid", 64'(o_mvld), 64'd0);
        chk("reset wr_count", 64'(o_wrc), 64'd0);
        chk("reset almost_empty", 64'(o_ae), 64'd1);
        chk("reset almost_full", 64'(o_af), 64'd0);
        chk("reset pkt s_tready", 64'(pk_s.tready), 64'd0);

        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Two-beat cut-through transfer from the table
        foreach (tbl[r]) begin
            s_vld = tbl[r].vld; s_data = tbl[r].d; s_last = tbl[r].last; m_rdy = tbl[r].rdy;
            step();
            chk("vec s_tready", 64'(o_srdy), 64'(tbl[r].e_srdy));
            chk("vec m_tvalid", 64'(o_mvld), 64'(tbl[r].e_mvld));
            chk("vec wr_count", 64'(o_wrc), 64'(tbl[r].e_cnt));
            if (tbl[r].e_chk) begin
                chk("vec tdata", o_data, tbl[r].e_d);
                chk("vec tlast", 64'(o_last), 64'(tbl[r].e_last));
            end
        end
        s_vld = 1'b0; s_last = 1'b0;

        // Fill with the reader stalled, then try a 17th beat
        m_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_vld  = 1'b1;
            s_data = 64'hF111_0000_0000_0000 + 64'(i);
            step();
            if (i == 12) chk("fill afull at 13", 64'(o_af), 64'd0);
            if (i == 13) chk("fill afull at 14", 64'(o_af), 64'd1);
            if (i == 15) begin
                chk("fill wr_count 16", 64'(o_wrc), 64'd16);
                chk("fill s_tready low", 64'(o_srdy), 64'd0);
            end
        end
        chk("fill 17th rejected", 64'(o_wrc), 64'd16);
        s_vld = 1'b0;
        m_rdy = 1'b1;
        step();
        m_rdy = 1'b0;
        chk("fill one read count", 64'(o_wrc), 64'd15);
        chk("fill one read s_tready", 64'(o_srdy), 64'd1);
        xfer("fill drain", 15, 15, 64'hF111_0000_0000_0001, 1000, 1'b0);
        chk("fill drain empty", 64'(o_wrc), 64'd0);

        // Randomly stalled streaming, wraps the pointers
        xfer("stream", 40, 0, 64'hA5A5_0000_0000_0000, 8, 1'b1);
        m_rdy = 1'b1;
        for (int c = 0; c < 40 && o_wrc != 0; c++) step();
        chk("stream empty", 64'(o_wrc), 64'd0);

        // Packet mode: 5-beat packet with gaps
        sel = 1'b1;
        m_rdy = 1'b1;
        for (int b = 0; b < 5; b++) begin
            s_vld  = 1'b1;
            s_data = 64'hC0DE_0000_0000_0000 + 64'(b);
            s_last = (b == 4);
            step();
            if (b < 4) begin
                chk("pkt5 m_tvalid held", 64'(o_mvld), 64'd0);
                chk("pkt5 rd_count held", 64'(o_rdc), 64'd0);
                chk("pkt5 pkt_count held", 64'(o_pkc), 64'd0);
                s_vld = 1'b0;
                step();
                chk("pkt5 gap m_tvalid", 64'(o_mvld), 64'd0);
            end else begin
                chk("pkt5 m_tvalid after last", 64'(o_mvld), 64'd1);
                chk("pkt5 pkt_count 1", 64'(o_pkc), 64'd1);
                chk("pkt5 rd_count 5", 64'(o_rdc), 64'd5);
            end
        end
        s_vld = 1'b0; s_last = 1'b0;
        xfer("pkt5", 5, 5, 64'hC0DE_0000_0000_0000, 5, 1'b0);
        chk("pkt5 pkt_count 0", 64'(o_pkc), 64'd0);
        chk("pkt5 m_tvalid done", 64'(o_mvld), 64'd0);

        // Packet mode: oversize 20-beat packet forces release at full
        m_rdy = 1'b0;
        for (int b = 0; b < 16; b++) begin
            s_vld  = 1'b1;
            s_data = 64'hB16B_0000_0000_0000 + 64'(b);
            s_last = 1'b0;
            step();
            if (b < 15) chk("pkt20 m_tvalid held", 64'(o_mvld), 64'd0);
        end
        s_vld = 1'b0;
        chk("pkt20 full count", 64'(o_wrc), 64'd16);
        chk("pkt20 forced m_tvalid", 64'(o_mvld), 64'd1);
        chk("pkt20 forced rd_count", 64'(o_rdc), 64'd16);
        chk("pkt20 s_tready low", 64'(o_srdy), 64'd0);
        xfer("pkt20", 20, 16, 64'hB16B_0000_0000_0000, 20, 1'b0);
        chk("pkt20 m_tvalid done", 64'(o_mvld), 64'd0);
        chk("pkt20 pkt_count 0", 64'(o_pkc), 64'd0);
        chk("pkt20 rd_count 0", 64'(o_rdc), 64'd0);

        // Asynchronous reset with the FIFO half full
        sel = 1'b0;
        m_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_vld  = 1'b1;
            s_data = 64'hAB00 + 64'(i);
            step();
        end
        s_vld = 1'b0;
        chk("half full count", 64'(o_wrc), 64'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst m_tvalid", 64'(o_mvld), 64'd0);
        chk("async rst wr_count", 64'(o_wrc), 64'd0);
        chk("async rst rd_count", 64'(o_rdc), 64'd0);
        chk("async rst s_tready", 64'(o_srdy), 64'd0);
        chk("async rst almost_empty", 64'(o_ae), 64'd1);
        @(posedge clk);
        #1;
        chk("rst held s_tready", 64'(o_srdy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post rst s_tready", 64'(o_srdy), 64'd1);
        chk("post rst m_tvalid", 64'(o_mvld), 64'd0);
        s_vld = 1'b1; s_data = 64'h600D; s_last = 1'b1;
        step();
        s_vld = 1'b0; s_last = 1'b0;
        chk("post rst m_tvalid new", 64'(o_mvld), 64'd1);
        chk("post rst tdata new", o_data, 64'h600D);
        m_rdy = 1'b1;
        step();
        chk("post rst drained", 64'(o_mvld), 64'd0);
        chk("post rst count 0", 64'(o_wrc), 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
